// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code decoder (E0/F0 prefixes) feeding a FWFT event FIFO, plus a held-key tracker.
// Optional build macro PS2_TYPEMATIC_FILTER_EN drops repeated makes of the currently held key.
module ps2_key_event_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 10_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     ps2_key_pressed_i,
  input  logic [7:0]               ps2_out_i,
  input  logic                     evt_ready_i,
  output logic                     evt_valid_o,
  output logic [7:0]               evt_code_o,
  output logic                     evt_break_o,
  output logic                     evt_ext_o,
  output logic [7:0]               held_key_o,
  output logic                     held_ext_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] HoldMax   = CNT_W'(HOLD_CYCLES);
  localparam logic [CW-1:0]    FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e      state_q;
  logic        emit_q;
  logic [7:0]  emit_code_q;
  logic        emit_brk_q;
  logic        emit_ext_q;

  // Decoder: prefixes accumulate into the state, a data byte emits one registered event.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= StIdle;
      emit_q      <= 1'b0;
      emit_code_q <= 8'h00;
      emit_brk_q  <= 1'b0;
      emit_ext_q  <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (ps2_key_pressed_i) begin
        if (ps2_out_i == 8'h00 || ps2_out_i == 8'hFF) begin
          state_q <= StIdle;
        end else if (ps2_out_i == 8'hE0) begin
          unique case (state_q)
            StIdle, StExt:   state_q <= StExt;
            StBrk, StExtBrk: state_q <= StExtBrk;
            default:         state_q <= StIdle;
          endcase
        end else if (ps2_out_i == 8'hF0) begin
          unique case (state_q)
            StIdle, StBrk:   state_q <= StBrk;
            StExt, StExtBrk: state_q <= StExtBrk;
            default:         state_q <= StIdle;
          endcase
        end else begin
          emit_q      <= 1'b1;
          emit_code_q <= ps2_out_i;
          emit_brk_q  <= (state_q == StBrk) || (state_q == StExtBrk);
          emit_ext_q  <= (state_q == StExt) || (state_q == StExtBrk);
          state_q     <= StIdle;
        end
      end
    end
  end

  logic [7:0]       held_key_q;
  logic             held_ext_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             is_make;
  logic             is_held;
  logic             drop_repeat;

  assign is_make = emit_q && !emit_brk_q;
  assign is_held = (emit_code_q == held_key_q) && (emit_ext_q == held_ext_q);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign drop_repeat = is_make && is_held && (held_key_q != 8'h00);
`else
  assign drop_repeat = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      held_key_q <= 8'h00;
      held_ext_q <= 1'b0;
      hold_cnt_q <= HoldMax;
    end else if (is_make) begin
      held_key_q <= emit_code_q;
      held_ext_q <= emit_ext_q;
      hold_cnt_q <= '0;
    end else if (emit_q && is_held) begin
      held_key_q <= 8'h00;
      held_ext_q <= 1'b0;
      hold_cnt_q <= HoldMax;
    end else if (hold_cnt_q < HoldMax) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
      if (hold_cnt_q == HoldMax - 1'b1) begin
        held_key_q <= 8'h00;
        held_ext_q <= 1'b0;
      end
    end
  end

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push_req, push, pop, full;

  assign full     = (count_q == FullCount);
  assign pop      = evt_ready_i && (count_q != '0);
  assign push_req = emit_q && !drop_repeat;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (push_req && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {emit_ext_q, emit_brk_q, emit_code_q};
  end

  logic [9:0] head;
  assign head         = mem_q[rptr_q];
  assign evt_valid_o  = (count_q != '0);
  assign evt_code_o   = evt_valid_o ? head[7:0] : 8'h00;
  assign evt_break_o  = evt_valid_o ? head[8] : 1'b0;
  assign evt_ext_o    = evt_valid_o ? head[9] : 1'b0;
  assign held_key_o   = held_key_q;
  assign held_ext_o   = held_ext_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue with DEPTH=4, HOLD_CYCLES=16.
module tb_ps2_key_event_queue;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_out = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_break, evt_ext, held_ext, overflow;
  logic [7:0] evt_code, held_key;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  ps2_key_event_queue #(
    .DEPTH       (4),
    .HOLD_CYCLES (16),
    .CNT_W       (5)
  ) dut (
    .clk_i             (clk),
    .resetn_i          (resetn),
    .ps2_key_pressed_i (ps2_key_pressed),
    .ps2_out_i         (ps2_out),
    .evt_ready_i       (evt_ready),
    .evt_valid_o       (evt_valid),
    .evt_code_o        (evt_code),
    .evt_break_o       (evt_break),
    .evt_ext_o         (evt_ext),
    .held_key_o        (held_key),
    .held_ext_o        (held_ext),
    .fifo_count_o      (fifo_count),
    .overflow_o        (overflow)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    ps2_key_pressed = 1'b1;
    ps2_out = b;
    @(negedge clk);
    ps2_key_pressed = 1'b0;
    ps2_out = 8'h00;
  endtask

  // Called at a negedge; pops the head on the following posedge.
  task automatic do_pop();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    vectors++;
    got = {evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow, held_ext};
    if (got !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected %h", got, 18'h0);
    end
    vectors++;
    if (held_key !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_held_key: got %h expected 00", held_key);
    end
  endtask

  task automatic test_make_and_hold();
    logic [10:0] got;
    strobe(8'h1C);
    idle(1);  // event written, hold counter = 0
    got = {evt_valid, evt_code, evt_break, evt_ext};
    vectors++;
    if (got !== {1'b1, 8'h1C, 2'b00}) begin
      miscompares++;
      $display("FAIL make_head: got %h expected %h", got, {1'b1, 8'h1C, 2'b00});
    end
    vectors++;
    if (fifo_count !== 3'd1 || held_key !== 8'h1C) begin
      miscompares++;
      $display("FAIL make_count_held: got %0d/%h expected 1/1c", fifo_count, held_key);
    end
    do_pop();  // counter = 1
    vectors++;
    if (evt_valid !== 1'b0 || evt_code !== 8'h00) begin
      miscompares++;
      $display("FAIL make_pop_empty: got %b/%h expected 0/00", evt_valid, evt_code);
    end
    idle(14);  // counter = 15
    vectors++;
    if (held_key !== 8'h1C) begin
      miscompares++;
      $display("FAIL hold_before_expiry: got %h expected 1c", held_key);
    end
    idle(1);   // counter = 16
    vectors++;
    if (held_key !== 8'h00) begin
      miscompares++;
      $display("FAIL hold_expiry: got %h expected 00", held_key);
    end
  endtask

  task automatic test_ext_break();
    logic [10:0] got;
    strobe(8'hE0);
    strobe(8'h75);
    idle(1);
    got = {evt_valid, evt_code, evt_break, evt_ext};
    vectors++;
    if (got !== {1'b1, 8'h75, 2'b01} || held_key !== 8'h75 || held_ext !== 1'b1) begin
      miscompares++;
      $display("FAIL ext_make: got %h held %h/%b expected %h held 75/1",
               got, held_key, held_ext, {1'b1, 8'h75, 2'b01});
    end
    do_pop();
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h75);
    idle(1);
    got = {evt_valid, evt_code, evt_break, evt_ext};
    vectors++;
    if (got !== {1'b1, 8'h75, 2'b11}) begin
      miscompares++;
      $display("FAIL ext_break_head: got %h expected %h", got, {1'b1, 8'h75, 2'b11});
    end
    vectors++;
    if (held_key !== 8'h00 || held_ext !== 1'b0) begin
      miscompares++;
      $display("FAIL ext_break_clear: got %h/%b expected 00/0", held_key, held_ext);
    end
    do_pop();
    strobe(8'h00);
    strobe(8'h1C);
    idle(1);
    got = {evt_valid, evt_code, evt_break, evt_ext};
    vectors++;
    if (got !== {1'b1, 8'h1C, 2'b00} || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL discard_00: got %h cnt %0d expected %h cnt 1",
               got, fifo_count, {1'b1, 8'h1C, 2'b00});
    end
    do_pop();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [4];
    exp_q = '{8'h1C, 8'h1D, 8'h1E, 8'h1F};
    for (int i = 0; i < 5; i++) strobe(8'h1C + 8'(i));
    idle(1);
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || evt_code !== 8'h1C) begin
      miscompares++;
      $display("FAIL overflow_state: got cnt %0d ovf %b head %h expected 4 1 1c",
               fifo_count, overflow, evt_code);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (evt_valid !== 1'b1 || evt_code !== exp_q[i]) begin
        miscompares++;
        $display("FAIL overflow_order[%0d]: got %b/%h expected 1/%h",
                 i, evt_valid, evt_code, exp_q[i]);
      end
      do_pop();
    end
    vectors++;
    if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drain: got cnt %0d ovf %b expected 0 1", fifo_count, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h1D, 8'h1E, 8'h1F, 8'h21};
    do_reset();
    for (int i = 0; i < 4; i++) strobe(8'h1C + 8'(i));
    idle(1);
    strobe(8'h21);
    do_pop();  // pop lands on the same edge as the push of 21
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop: got cnt %0d ovf %b expected 4 0", fifo_count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (evt_valid !== 1'b1 || evt_code !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_order[%0d]: got %b/%h expected 1/%h",
                 i, evt_valid, evt_code, exp_q[i]);
      end
      do_pop();
    end
  endtask

  task automatic test_typematic();
    logic [2:0] exp_cnt;
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd3;
`endif
    for (int i = 0; i < 3; i++) begin
      strobe(8'h1C);
      idle(1);
      vectors++;
      if (held_key !== 8'h1C) begin
        miscompares++;
        $display("FAIL typematic_held[%0d]: got %h expected 1c", i, held_key);
      end
    end
    vectors++;
    if (fifo_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL typematic_count: got %0d expected %0d", fifo_count, exp_cnt);
    end
    for (int i = 0; i < 3; i++) if (evt_valid) do_pop();
  endtask

  task automatic test_reset_mid_prefix();
    logic [10:0] got;
    strobe(8'h1C);
    idle(1);
    strobe(8'hE0);
    resetn = 1'b0;
    #1;
    vectors++;
    if (evt_valid !== 1'b0 || fifo_count !== 3'd0 || held_key !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got v %b cnt %0d held %h expected 0 0 00",
               evt_valid, fifo_count, held_key);
    end
    @(negedge clk);
    resetn = 1'b1;
    strobe(8'h74);
    idle(1);
    got = {evt_valid, evt_code, evt_break, evt_ext};
    vectors++;
    if (got !== {1'b1, 8'h74, 2'b00}) begin
      miscompares++;
      $display("FAIL prefix_lost: got %h expected %h", got, {1'b1, 8'h74, 2'b00});
    end
  endtask

  initial begin
    idle(2);
    test_reset();
    resetn = 1'b1;
    test_make_and_hold();
    test_ext_break();
    test_overflow();
    test_full_push_pop();
    test_typematic();
    test_reset_mid_prefix();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
